channel_intr_gen: RTL and testbench
===================================

Name: channel_intr_gen

Overview:
- Epoch/interrupt generator for one correlator channel; it produces the `intr_pulse` that clears the channel's pending do-init request.
- Divides `clk` into programmable accumulation epochs and emits a one-cycle `intr_pulse` at each epoch boundary.
- When `doinit` is pending at a boundary, captures the shadow init values into the active load registers. It then issues `load_strobe` together with `intr_pulse`, so a requested init is applied exactly on an epoch edge.

Parameters:
- CNT_W, 24, width of epoch period and down-counter.
- INIT_W, 32, width of each init phase word (code phase, carrier phase).
- EPOCH_W, 16, width of the epochs-since-init counter.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  channel run enable.
- intr_period  in  CNT_W  epoch length in clk cycles; values 0 and 1 are treated as 2.
- doinit  in  1  pending init request (level; clears itself after `intr_pulse`).
- init_code_phase  in  INIT_W  shadow code phase.
- init_carr_phase  in  INIT_W  shadow carrier phase.
- intr_pulse  out  1  one-cycle epoch boundary pulse.
- load_strobe  out  1  one-cycle pulse: load registers were updated this boundary.
- code_phase_load  out  INIT_W  active code phase init value.
- carr_phase_load  out  INIT_W  active carrier phase init value.
- epoch_cnt  out  EPOCH_W  epochs since last load; wraps.
- running  out  1  high in RUN state.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is asynchronous, active-low (`reset_n`), on `clk`.
  - Reset values: `intr_pulse`=0, `load_strobe`=0, `code_phase_load`=0, `carr_phase_load`=0, `epoch_cnt`=0, `running`=0, counter=0, state=IDLE.
- Effective period: Peff = max(`intr_period`, 2).
- States:
  - IDLE:
    - Counter held at Peff-1; no pulses.
    - `enable`=1 -> RUN next cycle, with counter = Peff-1.
  - RUN:
    - Counter decrements each cycle.
    - At the terminal cycle (counter==0): counter reloads Peff-1, sampling `intr_period` at that cycle. `intr_period` changes take effect only at reload.
    - The next cycle, `intr_pulse`=1 for exactly one cycle.
    - `enable`=0 -> IDLE next cycle. A pulse already scheduled from a terminal cycle still fires.
- Boundary spacing: consecutive `intr_pulse`s are exactly Peff cycles apart. The first pulse after entering RUN arrives Peff cycles after the RUN entry cycle.
- Init load:
  - `doinit` is sampled in the terminal cycle.
  - If 1, `code_phase_load`/`carr_phase_load` take `init_code_phase`/`init_carr_phase` on the same edge that raises `intr_pulse`.
  - `load_strobe` is asserted coincident with that `intr_pulse`.
  - `doinit` asserted at any non-terminal cycle has no effect until the next terminal cycle.
  - Because Peff>=2, a `doinit` that is still high in the `intr_pulse` cycle (before the requester clears it) cannot cause a second load.
- `epoch_cnt`:
  - +1 on each `intr_pulse` without `load_strobe`.
  - Set to 0 on `intr_pulse` with `load_strobe` (load wins).
  - Wraps modulo 2^EPOCH_W.
  - Held while IDLE.
- `doinit` while IDLE: ignored until RUN reaches a terminal cycle.
- `running` = (state==RUN), registered.
- Reset mid-epoch: everything returns to reset values immediately. A pending `doinit` is not remembered here; it is held by the requester.

Optional Feature:
- Macro: CHANNEL_INTR_STATUS_EN.
- With the macro defined, two extra ports are present:
  - `intr_clr` (in, 1).
  - `intr_status` (out, 1, reset 0).
- `intr_status` behaviour:
  - Sticky; set on `intr_pulse`, cleared on `intr_clr`.
  - Simultaneous set and clear: set wins.
- Without the macro: neither port exists, and all other behaviour is identical.

Decomposition:
- Shared package holds:
  - State encoding: IDLE=1'b0, RUN=1'b1.
  - Default widths: CNT_W, INIT_W, EPOCH_W.
  - Minimum period constant: 2.
- Sub-module `epoch_down_counter` (load, enable, terminal flag, CNT_W wide) is natural; all remaining logic stays in the top module.

Test Plan:
- `intr_period`=5, `enable` raised at cycle 10 -> `intr_pulse` at cycles 16, 21, 26; `epoch_cnt` = 1, 2, 3; `load_strobe` never asserts.
- `intr_period`=4, `init_code_phase`=0x12345678, `init_carr_phase`=0xCAFEF00D, `doinit` high mid-epoch and held until 1 cycle after `intr_pulse`:
  - At the next boundary, `load_strobe`=`intr_pulse`=1, both load registers take the shadow values, and `epoch_cnt`=0.
  - No second load on the following boundary.
- `intr_period`=0 and `intr_period`=1 -> pulses every 2 cycles.
- `intr_period` changed 6->3 mid-epoch -> the current epoch completes at 6 cycles, subsequent epochs are 3 cycles.
- `enable` dropped in the terminal cycle -> that one pulse still fires; then no pulses and `running`=0. Re-enable -> first pulse Peff cycles after RUN entry.
- `reset_n` low mid-epoch with `doinit`=1 -> all outputs 0 asynchronously, no load. With CHANNEL_INTR_STATUS_EN: `intr_clr` coincident with `intr_pulse` leaves `intr_status`=1.

Source files
------------

// File: rtl/channel_intr_gen_pkg.sv
// Shared definitions for the channel epoch/interrupt generator: FSM state
// encoding, default widths and the minimum effective epoch period.
package channel_intr_gen_pkg;

    localparam int DEF_CNT_W   = 24;  // epoch period / down-counter width
    localparam int DEF_INIT_W  = 32;  // code / carrier phase init word width
    localparam int DEF_EPOCH_W = 16;  // epochs-since-load counter width

    // Shortest legal epoch; programmed periods of 0 and 1 are stretched to this
    localparam int MIN_PERIOD  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage : channel_intr_gen_pkg

// File: rtl/channel_intr_gen_epoch_down_counter.sv
// Loadable epoch down-counter. Load has priority over decrement; the
// terminal flag is a plain decode of the count reaching zero and is
// qualified by the caller with its own run state.
module channel_intr_gen_epoch_down_counter
    import channel_intr_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Count register: reload when asked, otherwise step down while decrementing
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of its inputs regardless of block order.
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule : channel_intr_gen_epoch_down_counter

// File: rtl/channel_intr_gen.sv
// Epoch/interrupt generator for one correlator channel.
// Splits clk into programmable epochs, pulses intr_pulse one cycle after each
// terminal count, and applies a pending do-init (shadow -> active load
// registers, load_strobe) exactly on that epoch boundary.
// Optional build macro: CHANNEL_INTR_STATUS_EN adds intr_clr / intr_status
// (sticky interrupt status, set wins over clear).
module channel_intr_gen
    import channel_intr_gen_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int INIT_W  = DEF_INIT_W,
    parameter int EPOCH_W = DEF_EPOCH_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [CNT_W-1:0]   intr_period,
    input  logic               doinit,
    input  logic [INIT_W-1:0]  init_code_phase,
    input  logic [INIT_W-1:0]  init_carr_phase,
`ifdef CHANNEL_INTR_STATUS_EN
    input  logic               intr_clr,
    output logic               intr_status,
`endif
    output logic               intr_pulse,
    output logic               load_strobe,
    output logic [INIT_W-1:0]  code_phase_load,
    output logic [INIT_W-1:0]  carr_phase_load,
    output logic [EPOCH_W-1:0] epoch_cnt,
    output logic               running
);

    state_e             r_state;
    logic               r_intr_pulse;
    logic               r_load_strobe;
    logic [INIT_W-1:0]  r_code_phase_load;
    logic [INIT_W-1:0]  r_carr_phase_load;
    logic [EPOCH_W-1:0] r_epoch_cnt;

    logic [CNT_W-1:0]   w_reload_val;
    logic               w_cnt_zero;
    logic               w_terminal;
    logic               w_cnt_load;
    logic               w_cnt_dec;
    logic               w_do_load;

    // Reload value is Peff-1 with Peff = max(intr_period, MIN_PERIOD); it is
    // only consumed at a reload, so mid-epoch period writes wait for the edge.
    assign w_reload_val = (intr_period < CNT_W'(MIN_PERIOD))
                        ? CNT_W'(MIN_PERIOD - 1)
                        : intr_period - CNT_W'(1);

    // Terminal cycle: last cycle of an epoch while running. Not gated by
    // enable, so a boundary reached in the cycle enable drops still fires.
    assign w_terminal = (r_state == ST_RUN) && w_cnt_zero;

    // Hold the counter at Peff-1 whenever not actively counting, so RUN
    // entry always starts a full epoch.
    assign w_cnt_load = (r_state == ST_IDLE) || w_terminal || !enable;
    assign w_cnt_dec  = (r_state == ST_RUN);

    // A do-init only counts when sampled in the terminal cycle
    assign w_do_load  = w_terminal && doinit;

    channel_intr_gen_epoch_down_counter #(
        .CNT_W (CNT_W)
    ) u_epoch_down_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_reload_val),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // Run/idle FSM with registered boundary pulse, load strobe, load registers
    // and epoch counter, all updated on the edge that ends the terminal cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state           <= ST_IDLE;
            r_intr_pulse      <= 1'b0;
            r_load_strobe     <= 1'b0;
            // NOTE: the active load registers are observable outputs with a
            // defined reset value, so they are reset like any other state.
            r_code_phase_load <= '0;
            r_carr_phase_load <= '0;
            r_epoch_cnt       <= '0;
        end else begin
            r_intr_pulse  <= w_terminal;
            r_load_strobe <= w_do_load;

            if (w_do_load) begin
                r_code_phase_load <= init_code_phase;
                r_carr_phase_load <= init_carr_phase;
                r_epoch_cnt       <= '0;
            end else if (w_terminal) begin
                r_epoch_cnt       <= r_epoch_cnt + EPOCH_W'(1);
            end

            case (r_state)
                ST_IDLE: if (enable)  r_state <= ST_RUN;
                ST_RUN:  if (!enable) r_state <= ST_IDLE;
                default:              r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef CHANNEL_INTR_STATUS_EN
    logic r_intr_status;

    // Sticky status: set by the boundary pulse, cleared by intr_clr, set wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_intr_status <= 1'b0;
        end else if (r_intr_pulse) begin
            r_intr_status <= 1'b1;
        end else if (intr_clr) begin
            r_intr_status <= 1'b0;
        end
    end

    assign intr_status = r_intr_status;
`endif

    assign intr_pulse      = r_intr_pulse;
    assign load_strobe     = r_load_strobe;
    assign code_phase_load = r_code_phase_load;
    assign carr_phase_load = r_carr_phase_load;
    assign epoch_cnt       = r_epoch_cnt;
    assign running         = (r_state == ST_RUN);

endmodule : channel_intr_gen

// File: tb/tb_channel_intr_gen.sv
// Directed self-checking bench for channel_intr_gen. Cycle k in each test is
// the interval after the k-th rising edge following the cycle in which
// enable was raised; outputs are sampled 1 ns after each rising edge.
module tb_channel_intr_gen;

    localparam logic [31:0] CODE_VAL = 32'h1234_5678;
    localparam logic [31:0] CARR_VAL = 32'hCAFE_F00D;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [23:0] intr_period;
    logic        doinit;
    logic [31:0] init_code_phase;
    logic [31:0] init_carr_phase;
    logic        intr_pulse;
    logic        load_strobe;
    logic [31:0] code_phase_load;
    logic [31:0] carr_phase_load;
    logic [15:0] epoch_cnt;
    logic        running;
`ifdef CHANNEL_INTR_STATUS_EN
    logic        intr_clr;
    logic        intr_status;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    channel_intr_gen dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .intr_period     (intr_period),
        .doinit          (doinit),
        .init_code_phase (init_code_phase),
        .init_carr_phase (init_carr_phase),
`ifdef CHANNEL_INTR_STATUS_EN
        .intr_clr        (intr_clr),
        .intr_status     (intr_status),
`endif
        .intr_pulse      (intr_pulse),
        .load_strobe     (load_strobe),
        .code_phase_load (code_phase_load),
        .carr_phase_load (carr_phase_load),
        .epoch_cnt       (epoch_cnt),
        .running         (running)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n         = 1'b0;
        enable          = 1'b0;
        doinit          = 1'b0;
        intr_period     = 24'd5;
        init_code_phase = CODE_VAL;
        init_carr_phase = CARR_VAL;
`ifdef CHANNEL_INTR_STATUS_EN
        intr_clr        = 1'b0;
`endif
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        #2;
        tests_run++;
        if ({intr_pulse, load_strobe, running} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags got=%b exp=000", {intr_pulse, load_strobe, running});
        end
        tests_run++;
        if ({code_phase_load, carr_phase_load, epoch_cnt} !== 80'd0) begin
            tests_failed++;
            $display("FAIL reset_regs got code=%h carr=%h epoch=%0d exp all 0",
                     code_phase_load, carr_phase_load, epoch_cnt);
        end
`ifdef CHANNEL_INTR_STATUS_EN
        tests_run++;
        if (intr_status !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_status got=%b exp=0", intr_status);
        end
`endif
        reset_n = 1'b1;
        tick();
    endtask

    // Period 5: pulses at cycles 6, 11, 16 with epoch_cnt 1, 2, 3
    task automatic test_basic();
        logic exp_p;
        do_reset();
        intr_period = 24'd5;
        enable      = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp_p = (k == 6) || (k == 11) || (k == 16);
            tests_run++;
            if (intr_pulse !== exp_p) begin
                tests_failed++;
                $display("FAIL basic_pulse k=%0d got=%b exp=%b", k, intr_pulse, exp_p);
            end
            tests_run++;
            if (load_strobe !== 1'b0 || running !== 1'b1) begin
                tests_failed++;
                $display("FAIL basic_strobe_run k=%0d got strobe=%b run=%b exp strobe=0 run=1",
                         k, load_strobe, running);
            end
            if (exp_p) begin
                tests_run++;
                if (epoch_cnt !== 16'((k - 1) / 5)) begin
                    tests_failed++;
                    $display("FAIL basic_epoch k=%0d got=%0d exp=%0d", k, epoch_cnt, (k - 1) / 5);
                end
            end
        end
    endtask

    // Period 4: doinit rises at cycle 6, falls at cycle 11; load at boundary 9
    task automatic test_doinit();
        logic        exp_p;
        logic        exp_s;
        logic [15:0] exp_e;
        logic [31:0] exp_code;
        logic [31:0] exp_carr;
        do_reset();
        intr_period = 24'd4;
        enable      = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            exp_p    = (k == 5) || (k == 9) || (k == 13);
            exp_s    = (k == 9);
            exp_e    = (k < 5) ? 16'd0 : (k < 9) ? 16'd1 : (k < 13) ? 16'd0 : 16'd1;
            exp_code = (k < 9) ? 32'd0 : CODE_VAL;
            exp_carr = (k < 9) ? 32'd0 : CARR_VAL;
            tests_run++;
            if (intr_pulse !== exp_p || load_strobe !== exp_s) begin
                tests_failed++;
                $display("FAIL doinit_pulse k=%0d got pulse=%b strobe=%b exp pulse=%b strobe=%b",
                         k, intr_pulse, load_strobe, exp_p, exp_s);
            end
            tests_run++;
            if (epoch_cnt !== exp_e) begin
                tests_failed++;
                $display("FAIL doinit_epoch k=%0d got=%0d exp=%0d", k, epoch_cnt, exp_e);
            end
            tests_run++;
            if (code_phase_load !== exp_code || carr_phase_load !== exp_carr) begin
                tests_failed++;
                $display("FAIL doinit_load k=%0d got code=%h carr=%h exp code=%h carr=%h",
                         k, code_phase_load, carr_phase_load, exp_code, exp_carr);
            end
            if (k == 6)  doinit = 1'b1;
            if (k == 11) doinit = 1'b0;
        end
    endtask

    // Periods 0 and 1 behave as 2: pulses at odd cycles from 3
    task automatic test_min_period();
        logic exp_p;
        for (int p = 0; p <= 1; p++) begin
            do_reset();
            intr_period = 24'(p);
            enable      = 1'b1;
            for (int k = 1; k <= 10; k++) begin
                tick();
                exp_p = (k >= 3) && (k % 2 == 1);
                tests_run++;
                if (intr_pulse !== exp_p) begin
                    tests_failed++;
                    $display("FAIL min_period p=%0d k=%0d got=%b exp=%b", p, k, intr_pulse, exp_p);
                end
            end
            tests_run++;
            if (epoch_cnt !== 16'd4) begin
                tests_failed++;
                $display("FAIL min_period_epoch p=%0d got=%0d exp=4", p, epoch_cnt);
            end
        end
    endtask

    // Period 6 -> 3 written at cycle 3: pulses at 7, then 10, 13, 16
    task automatic test_period_change();
        logic exp_p;
        do_reset();
        intr_period = 24'd6;
        enable      = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            exp_p = (k == 7) || (k == 10) || (k == 13) || (k == 16);
            tests_run++;
            if (intr_pulse !== exp_p) begin
                tests_failed++;
                $display("FAIL period_change k=%0d got=%b exp=%b", k, intr_pulse, exp_p);
            end
            if (k == 3) intr_period = 24'd3;
        end
    endtask

    // Period 4: enable dropped in terminal cycle 8; pulse 9 still fires
    task automatic test_enable_drop();
        logic exp_p;
        logic exp_r;
        do_reset();
        intr_period = 24'd4;
        enable      = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            exp_p = (k == 5) || (k == 9);
            exp_r = (k <= 8);
            tests_run++;
            if (intr_pulse !== exp_p || running !== exp_r) begin
                tests_failed++;
                $display("FAIL enable_drop k=%0d got pulse=%b run=%b exp pulse=%b run=%b",
                         k, intr_pulse, running, exp_p, exp_r);
            end
            if (k == 8) enable = 1'b0;
        end
        tests_run++;
        if (epoch_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL enable_drop_hold got=%0d exp=2", epoch_cnt);
        end
        enable = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            tick();
            exp_p = (j == 5);
            tests_run++;
            if (intr_pulse !== exp_p || running !== 1'b1) begin
                tests_failed++;
                $display("FAIL reenable j=%0d got pulse=%b run=%b exp pulse=%b run=1",
                         j, intr_pulse, running, exp_p);
            end
        end
        tests_run++;
        if (epoch_cnt !== 16'd3) begin
            tests_failed++;
            $display("FAIL reenable_epoch got=%0d exp=3", epoch_cnt);
        end
    endtask

    // Reset mid-epoch with doinit high: immediate clear, no load afterwards
    task automatic test_reset_mid();
        do_reset();
        intr_period = 24'd4;
        enable      = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) doinit = 1'b1;
        end
        tests_run++;
        if (running !== 1'b1 || epoch_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL reset_mid_pre got run=%b epoch=%0d exp run=1 epoch=1", running, epoch_cnt);
        end
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({intr_pulse, load_strobe, running} !== 3'b000 || epoch_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_async got flags=%b epoch=%0d exp flags=000 epoch=0",
                     {intr_pulse, load_strobe, running}, epoch_cnt);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if (load_strobe !== 1'b0 || code_phase_load !== 32'd0 || carr_phase_load !== 32'd0) begin
                tests_failed++;
                $display("FAIL reset_mid_noload k=%0d got strobe=%b code=%h carr=%h exp 0",
                         k, load_strobe, code_phase_load, carr_phase_load);
            end
        end
        doinit  = 1'b0;
        enable  = 1'b0;
        reset_n = 1'b1;
        tick();
    endtask

`ifdef CHANNEL_INTR_STATUS_EN
    // Period 2: pulses at 3 and 5; clear coincident with pulse 3 loses
    task automatic test_status();
        do_reset();
        intr_period = 24'd2;
        enable      = 1'b1;
        tick();
        tick();
        tick();
        intr_clr = 1'b1;
        tests_run++;
        if (intr_pulse !== 1'b1 || intr_status !== 1'b0) begin
            tests_failed++;
            $display("FAIL status_pre got pulse=%b status=%b exp pulse=1 status=0", intr_pulse, intr_status);
        end
        tick();
        tests_run++;
        if (intr_status !== 1'b1) begin
            tests_failed++;
            $display("FAIL status_set_wins got=%b exp=1", intr_status);
        end
        tick();
        intr_clr = 1'b0;
        tests_run++;
        if (intr_status !== 1'b0) begin
            tests_failed++;
            $display("FAIL status_clear got=%b exp=0", intr_status);
        end
        tick();
        tests_run++;
        if (intr_status !== 1'b1) begin
            tests_failed++;
            $display("FAIL status_reset got=%b exp=1", intr_status);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_doinit();
        test_min_period();
        test_period_change();
        test_enable_drop();
        test_reset_mid();
`ifdef CHANNEL_INTR_STATUS_EN
        test_status();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_channel_intr_gen
